// File: rtl/image_roi_crop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : image_roi_crop_pkg
// Description : Shared stream data-type codes and state encoding for the
//               region-of-interest crop stage.
// Revision    : 1.0 - initial release
// ============================================================================
package image_roi_crop_pkg;

    // Width of the dtype side-band that travels with every stream word
    localparam int DTYPE_WIDTH = 4;

    // Stream token codes produced by imager_rx
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 4'h1;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = 4'h2;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START    = 4'h3;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END      = 4'h4;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL        = 4'h5;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = 4'h6;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = 4'h7;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_END   = 4'h8;

    // Frame tracking states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_HDR   = 2'd2
    } crop_state_e;

endpackage
`default_nettype wire

// File: rtl/image_roi_window_cmp.sv
`default_nettype none
// ============================================================================
// Module      : image_roi_window_cmp
// Description : Combinational one-axis window test. A zero window size means
//               the axis is not cropped. The range end is computed one bit
//               wider than the inputs so start+num never wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module image_roi_window_cmp #(
    parameter int DIM_WIDTH = 16
) (
    input  logic [DIM_WIDTH:0]   coord,
    input  logic [DIM_WIDTH-1:0] start,
    input  logic [DIM_WIDTH-1:0] num,
    output logic                 ok
);

    logic [DIM_WIDTH:0] lo_w;
    logic [DIM_WIDTH:0] hi_w;

    // Inclusive lower bound, exclusive upper bound, widened by one bit
    always_comb begin
        lo_w = {1'b0, start};
        hi_w = {1'b0, start} + {1'b0, num};
        ok   = (num == '0) || ((coord >= lo_w) && (coord < hi_w));
    end

endmodule
`default_nettype wire

// File: rtl/image_roi_crop.sv
`default_nettype none
// ============================================================================
// Module      : image_roi_crop
// Description : Streaming region-of-interest crop. Forwards framing and header
//               tokens untouched, keeps only rows/pixels inside the window,
//               renumbers ROW_START tokens and reports emitted frame size.
// Revision    : 1.0 - initial release
// ============================================================================
module image_roi_crop
    import image_roi_crop_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                   clki,
    input  logic                   resetb_clki,
    input  logic                   enable,
    input  logic [DIM_WIDTH-1:0]   crop_row_start,
    input  logic [DIM_WIDTH-1:0]   crop_col_start,
    input  logic [DIM_WIDTH-1:0]   crop_num_rows,
    input  logic [DIM_WIDTH-1:0]   crop_num_cols,
    input  logic                   dvi,
    input  logic [DTYPE_WIDTH-1:0] dtypei,
    input  logic [DATA_WIDTH-1:0]  datai,
    output logic                   dvo,
    output logic [DTYPE_WIDTH-1:0] dtypeo,
    output logic [DATA_WIDTH-1:0]  datao,
    output logic [DIM_WIDTH-1:0]   out_num_rows,
    output logic [DIM_WIDTH-1:0]   out_num_cols
);

    localparam logic [DIM_WIDTH:0]   ONE_W = 1;
    localparam logic [DIM_WIDTH-1:0] ONE_D = 1;

    // Frame-latched crop settings
    logic                   en_q, en_d;
    logic [DIM_WIDTH-1:0]   row_start_q, row_start_d;
    logic [DIM_WIDTH-1:0]   col_start_q, col_start_d;
    logic [DIM_WIDTH-1:0]   num_rows_q, num_rows_d;
    logic [DIM_WIDTH-1:0]   num_cols_q, num_cols_d;

    // Input position and emitted-size bookkeeping
    logic [DIM_WIDTH:0]     in_row_q, in_row_d;
    logic [DIM_WIDTH:0]     in_col_q, in_col_d;
    logic [DIM_WIDTH-1:0]   out_row_cnt_q, out_row_cnt_d;
    logic [DIM_WIDTH-1:0]   row_pix_cnt_q, row_pix_cnt_d;
    logic [DIM_WIDTH-1:0]   col_shadow_q, col_shadow_d;
    crop_state_e            state_q, state_d;

    // Registered outputs
    logic                   dvo_q, dvo_d;
    logic [DTYPE_WIDTH-1:0] dtypeo_q, dtypeo_d;
    logic [DATA_WIDTH-1:0]  datao_q, datao_d;
    logic [DIM_WIDTH-1:0]   out_num_rows_q, out_num_rows_d;
    logic [DIM_WIDTH-1:0]   out_num_cols_q, out_num_cols_d;

    logic                   row_ok_w;
    logic                   col_ok_w;
    logic                   keep_w;
    logic [DIM_WIDTH-1:0]   fe_rows_w;
    logic [DIM_WIDTH-1:0]   fe_cols_w;

    image_roi_window_cmp #(.DIM_WIDTH(DIM_WIDTH)) u_row_cmp (
        .coord (in_row_q),
        .start (row_start_q),
        .num   (num_rows_q),
        .ok    (row_ok_w)
    );

    image_roi_window_cmp #(.DIM_WIDTH(DIM_WIDTH)) u_col_cmp (
        .coord (in_col_q),
        .start (col_start_q),
        .num   (num_cols_q),
        .ok    (col_ok_w)
    );

    // Decide whether the incoming word is kept and update all bookkeeping
    always_comb begin
        en_d           = en_q;
        row_start_d    = row_start_q;
        col_start_d    = col_start_q;
        num_rows_d     = num_rows_q;
        num_cols_d     = num_cols_q;
        in_row_d       = in_row_q;
        in_col_d       = in_col_q;
        out_row_cnt_d  = out_row_cnt_q;
        row_pix_cnt_d  = row_pix_cnt_q;
        col_shadow_d   = col_shadow_q;
        state_d        = state_q;
        dvo_d          = 1'b0;
        dtypeo_d       = dtypeo_q;
        datao_d        = datao_q;
        out_num_rows_d = out_num_rows_q;
        out_num_cols_d = out_num_cols_q;
        keep_w         = 1'b1;

        // A final row lacking ROW_END still counts if it emitted pixels
        if (row_pix_cnt_q != '0) begin
            fe_rows_w = (&out_row_cnt_q) ? out_row_cnt_q : out_row_cnt_q + ONE_D;
            fe_cols_w = row_pix_cnt_q;
        end else begin
            fe_rows_w = out_row_cnt_q;
            fe_cols_w = col_shadow_q;
        end

        if (dvi) begin
            datao_d = datai;
            case (dtypei)
                DTYPE_FRAME_START: begin
                    en_d          = enable;
                    row_start_d   = crop_row_start;
                    col_start_d   = crop_col_start;
                    num_rows_d    = crop_num_rows;
                    num_cols_d    = crop_num_cols;
                    in_row_d      = '0;
                    in_col_d      = '0;
                    out_row_cnt_d = '0;
                    row_pix_cnt_d = '0;
                    col_shadow_d  = '0;
                    state_d       = ST_FRAME;
                end
                DTYPE_FRAME_END: begin
                    out_num_rows_d = fe_rows_w;
                    out_num_cols_d = fe_cols_w;
                    out_row_cnt_d  = fe_rows_w;
                    col_shadow_d   = fe_cols_w;
                    row_pix_cnt_d  = '0;
                    if (state_q == ST_FRAME) begin
                        state_d = ST_HDR;
                    end
                end
                DTYPE_HEADER_END: begin
                    if (state_q == ST_HDR) begin
                        state_d = ST_IDLE;
                    end
                end
                DTYPE_ROW_START: begin
                    keep_w   = !en_q || row_ok_w;
                    in_col_d = '0;
                    // Renumber rows so the cropped image starts at row 0
                    if (en_q) begin
                        datao_d = DATA_WIDTH'(out_row_cnt_q);
                    end
                end
                DTYPE_ROW_END: begin
                    keep_w   = !en_q || row_ok_w;
                    in_row_d = (&in_row_q) ? in_row_q : in_row_q + ONE_W;
                    if (keep_w) begin
                        out_row_cnt_d = (&out_row_cnt_q) ? out_row_cnt_q : out_row_cnt_q + ONE_D;
                        col_shadow_d  = row_pix_cnt_q;
                        row_pix_cnt_d = '0;
                    end
                end
                DTYPE_PIXEL: begin
                    keep_w   = !en_q || (row_ok_w && col_ok_w);
                    in_col_d = (&in_col_q) ? in_col_q : in_col_q + ONE_W;
                    if (keep_w) begin
                        row_pix_cnt_d = (&row_pix_cnt_q) ? row_pix_cnt_q : row_pix_cnt_q + ONE_D;
                    end
                end
                default: keep_w = 1'b1;
            endcase
            dvo_d = keep_w;
            if (keep_w) begin
                dtypeo_d = dtypei;
            end else begin
                datao_d = datao_q;
            end
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clki or negedge resetb_clki) begin
        if (!resetb_clki) begin
            en_q           <= 1'b0;
            row_start_q    <= '0;
            col_start_q    <= '0;
            num_rows_q     <= '0;
            num_cols_q     <= '0;
            in_row_q       <= '0;
            in_col_q       <= '0;
            out_row_cnt_q  <= '0;
            row_pix_cnt_q  <= '0;
            col_shadow_q   <= '0;
            state_q        <= ST_IDLE;
            dvo_q          <= 1'b0;
            dtypeo_q       <= '0;
            datao_q        <= '0;
            out_num_rows_q <= '0;
            out_num_cols_q <= '0;
        end else begin
            en_q           <= en_d;
            row_start_q    <= row_start_d;
            col_start_q    <= col_start_d;
            num_rows_q     <= num_rows_d;
            num_cols_q     <= num_cols_d;
            in_row_q       <= in_row_d;
            in_col_q       <= in_col_d;
            out_row_cnt_q  <= out_row_cnt_d;
            row_pix_cnt_q  <= row_pix_cnt_d;
            col_shadow_q   <= col_shadow_d;
            state_q        <= state_d;
            dvo_q          <= dvo_d;
            dtypeo_q       <= dtypeo_d;
            datao_q        <= datao_d;
            out_num_rows_q <= out_num_rows_d;
            out_num_cols_q <= out_num_cols_d;
        end
    end

    assign dvo          = dvo_q;
    assign dtypeo       = dtypeo_q;
    assign datao        = datao_q;
    assign out_num_rows = out_num_rows_q;
    assign out_num_cols = out_num_cols_q;

endmodule
`default_nettype wire

// File: tb/tb_image_roi_crop.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_roi_crop
// Description : Directed, scoreboard-based bench for image_roi_crop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_roi_crop;
    import image_roi_crop_pkg::*;

    localparam int DW = 16;
    localparam int MW = 16;

    logic                   clki = 1'b0;
    logic                   resetb_clki;
    logic                   enable;
    logic [MW-1:0]          crop_row_start, crop_col_start, crop_num_rows, crop_num_cols;
    logic                   dvi;
    logic [DTYPE_WIDTH-1:0] dtypei;
    logic [DW-1:0]          datai;
    logic                   dvo;
    logic [DTYPE_WIDTH-1:0] dtypeo;
    logic [DW-1:0]          datao;
    logic [MW-1:0]          out_num_rows, out_num_cols;

    typedef struct packed {
        logic [DTYPE_WIDTH-1:0] t;
        logic [DW-1:0]          d;
    } word_t;

    word_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    er, ec;

    always #5 clki = ~clki;

    image_roi_crop #(.DATA_WIDTH(DW), .DIM_WIDTH(MW)) dut (
        .clki           (clki),
        .resetb_clki    (resetb_clki),
        .enable         (enable),
        .crop_row_start (crop_row_start),
        .crop_col_start (crop_col_start),
        .crop_num_rows  (crop_num_rows),
        .crop_num_cols  (crop_num_cols),
        .dvi            (dvi),
        .dtypei         (dtypei),
        .datai          (datai),
        .dvo            (dvo),
        .dtypeo         (dtypeo),
        .datao          (datao),
        .out_num_rows   (out_num_rows),
        .out_num_cols   (out_num_cols)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every emitted word against the oldest expected word
    always @(negedge clki) begin
        word_t w;
        if (resetb_clki === 1'b1 && dvo === 1'b1) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_dvo: observed dtype %0h data %0h expected no word", dtypeo, datao);
            end
            if (sb.size() != 0) begin
                w = sb.pop_front();
                check("dtypeo", 32'(dtypeo), 32'(w.t));
                check("datao", 32'(datao), 32'(w.d));
            end
        end
    end

    task automatic send(input logic [DTYPE_WIDTH-1:0] t, input logic [DW-1:0] d,
                        input bit keep, input logic [DW-1:0] ed);
        word_t w;
        @(posedge clki); #1;
        dvi = 1'b1; dtypei = t; datai = d;
        if (keep) begin
            w.t = t; w.d = ed;
            sb.push_back(w);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clki); #1;
            dvi = 1'b0;
        end
    endtask

    task automatic set_cfg(input bit en, input int rs, input int cs, input int nr, input int nc);
        enable = en;
        crop_row_start = MW'(rs); crop_col_start = MW'(cs);
        crop_num_rows  = MW'(nr); crop_num_cols  = MW'(nc);
    endtask

    // Drive one frame plus header block; expectations come from the
    // latched settings passed in and the known (row, col) of each word.
    task automatic run_frame(input int rows, input int cols, input bit en,
                             input int rs, input int cs, input int nr, input int nc,
                             input bit no_first_rs, input bit no_last_re,
                             input logic [DW-1:0] seed, input logic [DW-1:0] rs_xor,
                             input int chg_row, input int chg_cs,
                             output int exp_rows, output int exp_cols);
        int  oidx;
        int  npix;
        bit  row_ok, col_ok, k;
        logic [DW-1:0] d;
        oidx = 0; exp_cols = 0;
        send(DTYPE_FRAME_START, seed, 1'b1, seed);
        for (int r = 0; r < rows; r++) begin
            if (r == chg_row) crop_col_start = MW'(chg_cs);
            row_ok = (nr == 0) || (r >= rs && r < rs + nr);
            if (!(r == 0 && no_first_rs)) begin
                d = DW'(r) ^ rs_xor;
                send(DTYPE_ROW_START, d, !en || row_ok, en ? DW'(oidx) : d);
            end
            npix = 0;
            for (int c = 0; c < cols; c++) begin
                col_ok = (nc == 0) || (c >= cs && c < cs + nc);
                k = !en || (row_ok && col_ok);
                d = DW'(seed + r * 16 + c);
                send(DTYPE_PIXEL, d, k, d);
                if (k) npix++;
            end
            if (!(r == rows - 1 && no_last_re)) begin
                d = DW'(seed + r);
                send(DTYPE_ROW_END, d, !en || row_ok, d);
                if (!en || row_ok) begin
                    oidx++; exp_cols = npix;
                end
            end else if (npix > 0) begin
                oidx++; exp_cols = npix;
            end
        end
        exp_rows = oidx;
        send(DTYPE_FRAME_END,    seed ^ 16'h00F0, 1'b1, seed ^ 16'h00F0);
        send(DTYPE_HEADER_START, 16'hA5A5, 1'b1, 16'hA5A5);
        send(DTYPE_HEADER,       16'h1234, 1'b1, 16'h1234);
        send(DTYPE_HEADER,       16'hBEEF, 1'b1, 16'hBEEF);
        send(DTYPE_HEADER_END,   16'h5A5A, 1'b1, 16'h5A5A);
        idle(3);
    endtask

    task automatic check_status(input string tag, input int rows, input int cols);
        @(negedge clki);
        check({tag, "_rows"}, 32'(out_num_rows), 32'(rows));
        check({tag, "_cols"}, 32'(out_num_cols), 32'(cols));
    endtask

    initial begin
        resetb_clki = 1'b0;
        dvi = 1'b0; dtypei = '0; datai = '0;
        set_cfg(1'b0, 0, 0, 0, 0);
        repeat (3) @(posedge clki);
        #1 resetb_clki = 1'b1;
        @(negedge clki);
        check("rst_dvo", 32'(dvo), 32'd0);
        check("rst_dtypeo", 32'(dtypeo), 32'd0);
        check("rst_datao", 32'(datao), 32'd0);
        check("rst_rows", 32'(out_num_rows), 32'd0);
        check("rst_cols", 32'(out_num_cols), 32'd0);

        // Basic crop: rows 2..4, cols 3..6
        set_cfg(1'b1, 2, 3, 3, 4);
        run_frame(6, 8, 1'b1, 2, 3, 3, 4, 1'b0, 1'b0, 16'h1000, 16'h0, -1, 0, er, ec);
        check_status("crop", er, ec);
        check("crop_rows_const", 32'(out_num_rows), 32'd3);

        // No cropping on either axis
        set_cfg(1'b1, 0, 0, 0, 0);
        run_frame(6, 8, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 16'h2000, 16'h0, -1, 0, er, ec);
        check_status("nocrop", er, ec);
        check("nocrop_cols_const", 32'(out_num_cols), 32'd8);

        // Column start changed mid-frame: only the next frame sees it
        set_cfg(1'b1, 2, 3, 3, 4);
        run_frame(6, 8, 1'b1, 2, 3, 3, 4, 1'b0, 1'b0, 16'h3000, 16'h0, 2, 0, er, ec);
        check_status("midchg", er, ec);
        run_frame(6, 8, 1'b1, 2, 0, 3, 4, 1'b0, 1'b0, 16'h3800, 16'h0, -1, 0, er, ec);
        check_status("midchg_next", er, ec);

        // Missing first ROW_START and last ROW_END
        set_cfg(1'b1, 0, 0, 6, 5);
        run_frame(6, 8, 1'b1, 0, 0, 6, 5, 1'b1, 1'b1, 16'h4000, 16'h0, -1, 0, er, ec);
        check_status("nomark", er, ec);
        check("nomark_rows_const", 32'(out_num_rows), 32'd6);

        // Window starts beyond the image
        set_cfg(1'b1, 100, 0, 4, 0);
        run_frame(6, 8, 1'b1, 100, 0, 4, 0, 1'b0, 1'b0, 16'h5000, 16'h0, -1, 0, er, ec);
        check_status("empty", 0, 0);

        // Bypass: crop settings ignored, ROW_START data untouched
        set_cfg(1'b0, 2, 3, 3, 4);
        run_frame(6, 8, 1'b0, 2, 3, 3, 4, 1'b0, 1'b0, 16'h6000, 16'h0055, -1, 0, er, ec);
        check_status("bypass", 6, 8);

        // start+num overflows the coordinate width
        set_cfg(1'b1, 0, 1, 0, 16'hFFFF);
        run_frame(6, 8, 1'b1, 0, 1, 0, 16'hFFFF, 1'b0, 1'b0, 16'h7000, 16'h0, -1, 0, er, ec);
        check_status("wide", 6, 7);

        // Reset mid-row, bypass until next FRAME_START, then crop again
        set_cfg(1'b1, 2, 3, 3, 4);
        send(DTYPE_FRAME_START, 16'h0BAD, 1'b1, 16'h0BAD);
        send(DTYPE_ROW_START, 16'h0000, 1'b0, 16'h0);
        send(DTYPE_PIXEL, 16'h0001, 1'b0, 16'h0);
        idle(2);
        @(posedge clki); #1;
        dvi = 1'b1; dtypei = DTYPE_PIXEL; datai = 16'h0002;
        resetb_clki = 1'b0;
        @(negedge clki);
        check("rstmid_dvo", 32'(dvo), 32'd0);
        check("rstmid_rows", 32'(out_num_rows), 32'd0);
        @(posedge clki); #1;
        dvi = 1'b0;
        resetb_clki = 1'b1;
        send(DTYPE_ROW_START, 16'h0077, 1'b1, 16'h0077);
        for (int c = 0; c < 4; c++) send(DTYPE_PIXEL, DW'(16'h0900 + c), 1'b1, DW'(16'h0900 + c));
        send(DTYPE_ROW_END, 16'h0078, 1'b1, 16'h0078);
        idle(2);
        set_cfg(1'b1, 1, 2, 2, 3);
        run_frame(6, 8, 1'b1, 1, 2, 2, 3, 1'b0, 1'b0, 16'h8000, 16'h0030, -1, 0, er, ec);
        check_status("after_rst", er, ec);
        check("after_rst_cols_const", 32'(out_num_cols), 32'd3);

        idle(2);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
